soc_stim_sequencer: RTL and testbench

Synthesizable, table-driven stimulus sequencer for the miniRV SoC. It holds the SoC in reset for a programmable number of cycles. It then plays a loaded table of switch/button patterns, each held for a per-step dwell count, with optional looping. It drives the SoC's `fpga_rst`, `sw` and `button` inputs, either from a simulation top or from an on-board self-test wrapper, and replaces hand-written delay sequences with a parametrised, cycle-exact engine.

---
 rtl/soc_stim_pkg.sv | 19 +
 rtl/soc_stim_sequencer_if.sv | 46 ++++
 rtl/soc_stim_table.sv | 18 +
 rtl/soc_stim_sequencer.sv | 132 +++++++++++++
 tb/tb_soc_stim_sequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/soc_stim_pkg.sv
// soc_stim_pkg: shared types and widths for the table-driven SoC stimulus sequencer.
// SOC_STIM_LED_CHECK_EN adds expected-LED/mask fields to each table entry.
package soc_stim_pkg;
   localparam int ERR_CNT_W   = 16;
   localparam int ENT_SW_W    = 24;
   localparam int ENT_BTN_W   = 5;
   localparam int ENT_DWELL_W = 32;
   localparam int ENT_LED_W   = 24;
   typedef enum logic [1:0] {IDLE, HOLD, APPLY, DONE} state_t;
   typedef struct packed {
      logic [ENT_SW_W-1:0]    sw;
      logic [ENT_BTN_W-1:0]   btn;
      logic [ENT_DWELL_W-1:0] dwell;
`ifdef SOC_STIM_LED_CHECK_EN
      logic [ENT_LED_W-1:0]   exp_led;
      logic [ENT_LED_W-1:0]   led_mask;
`endif
   } entry_t;
endpackage

// File: rtl/soc_stim_sequencer_if.sv
// soc_stim_sequencer_if: control, table-load and SoC-drive bundle of the stimulus sequencer.
// SOC_STIM_LED_CHECK_EN adds the cfg_exp_led/cfg_led_mask table-load lines.
interface soc_stim_sequencer_if import soc_stim_pkg::*; #(
   parameter int SW_W    = 24,
   parameter int BTN_W   = 5,
   parameter int LED_W   = 24,
   parameter int DEPTH   = 8,
   parameter int DWELL_W = 32
);
   localparam int AW = $clog2(DEPTH);
   logic                 start;
   logic                 loop_en;
   logic                 cfg_we;
   logic [AW-1:0]        cfg_addr;
   logic [SW_W-1:0]      cfg_sw;
   logic [BTN_W-1:0]     cfg_btn;
   logic [DWELL_W-1:0]   cfg_dwell;
   logic [AW:0]          cfg_len;
`ifdef SOC_STIM_LED_CHECK_EN
   logic [LED_W-1:0]     cfg_exp_led;
   logic [LED_W-1:0]     cfg_led_mask;
`endif
   logic [LED_W-1:0]     led;
   logic                 soc_rst;
   logic [SW_W-1:0]      sw;
   logic [BTN_W-1:0]     button;
   logic [AW-1:0]        step_idx;
   logic                 busy;
   logic                 done;
   logic                 mismatch;
   logic [ERR_CNT_W-1:0] err_count;
   modport master (
`ifdef SOC_STIM_LED_CHECK_EN
      output cfg_exp_led, cfg_led_mask,
`endif
      output start, loop_en, cfg_we, cfg_addr, cfg_sw, cfg_btn, cfg_dwell, cfg_len, led,
      input  soc_rst, sw, button, step_idx, busy, done, mismatch, err_count
   );
   modport slave (
`ifdef SOC_STIM_LED_CHECK_EN
      input  cfg_exp_led, cfg_led_mask,
`endif
      input  start, loop_en, cfg_we, cfg_addr, cfg_sw, cfg_btn, cfg_dwell, cfg_len, led,
      output soc_rst, sw, button, step_idx, busy, done, mismatch, err_count
   );
endinterface

// File: rtl/soc_stim_table.sv
// soc_stim_table: DEPTH-entry stimulus register file, synchronous write, asynchronous read.
// Entry layout follows SOC_STIM_LED_CHECK_EN through entry_t; contents are never reset.
module soc_stim_table import soc_stim_pkg::*; #(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata
);
   entry_t mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/soc_stim_sequencer.sv
// soc_stim_sequencer: holds the SoC in reset, then plays a table of sw/button steps with dwell counts.
// SOC_STIM_LED_CHECK_EN enables per-step LED compare with mismatch pulse and saturating err_count.
module soc_stim_sequencer import soc_stim_pkg::*; #(
   parameter int SW_W       = 24,
   parameter int BTN_W      = 5,
   parameter int LED_W      = 24,
   parameter int DEPTH      = 8,
   parameter int DWELL_W    = 32,
   parameter int RST_CYCLES = 1000
) (
   input logic                fpga_clk,
   input logic                fpga_rst,
   soc_stim_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int HW = $clog2(RST_CYCLES + 1);
   state_t             state, nxt_state;
   logic [AW-1:0]      step_idx, nxt_idx;
   logic [LW-1:0]      len_q, len_in;
   logic [HW-1:0]      hold_cnt;
   logic [DWELL_W-1:0] dwell_cnt, ent_dwell;
   logic               idle_like, go, hold_end, step_end, pass_end, enter_step;
   entry_t             wr_ent, rd_ent;
   // The table is read at the upcoming index so a step's outputs load on the edge that enters it.
   soc_stim_table #(.DEPTH(DEPTH)) u_table (
      .clk   (fpga_clk),
      .we    (bus.cfg_we && idle_like),
      .waddr (bus.cfg_addr),
      .wdata (wr_ent),
      .raddr (nxt_idx),
      .rdata (rd_ent)
   );
   always_comb begin
      wr_ent          = '0;
      wr_ent.sw       = ENT_SW_W'(bus.cfg_sw);
      wr_ent.btn      = ENT_BTN_W'(bus.cfg_btn);
      wr_ent.dwell    = ENT_DWELL_W'(bus.cfg_dwell);
`ifdef SOC_STIM_LED_CHECK_EN
      wr_ent.exp_led  = ENT_LED_W'(bus.cfg_exp_led);
      wr_ent.led_mask = ENT_LED_W'(bus.cfg_led_mask);
`endif
   end
   always_comb begin
      idle_like  = (state == IDLE) || (state == DONE);
      go         = idle_like && bus.start;
      len_in     = (bus.cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.cfg_len;
      hold_end   = (state == HOLD) && (hold_cnt == '0);
      step_end   = (state == APPLY) && (dwell_cnt == '0);
      pass_end   = step_end && ({1'b0, step_idx} == len_q - LW'(1));
      ent_dwell  = DWELL_W'(rd_ent.dwell);
      nxt_state  = state;
      nxt_idx    = step_idx;
      if (go) begin
         nxt_state = (len_in == '0) ? DONE : HOLD;
         nxt_idx   = '0;
      end else if (hold_end) begin
         nxt_state = APPLY;
         nxt_idx   = '0;
      end else if (step_end) begin
         nxt_state = (pass_end && !bus.loop_en) ? DONE : APPLY;
         nxt_idx   = pass_end ? '0 : step_idx + AW'(1);
      end
      enter_step = (hold_end || step_end) && (nxt_state == APPLY);
   end
   always_ff @(posedge fpga_clk)
      state <= fpga_rst ? IDLE : nxt_state;
   always_ff @(posedge fpga_clk) begin
      if (fpga_rst) begin
         step_idx    <= '0;
         len_q       <= '0;
         hold_cnt    <= '0;
         dwell_cnt   <= '0;
         bus.soc_rst <= 1'b1;
         bus.sw      <= '0;
         bus.button  <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         step_idx <= nxt_idx;
         bus.busy <= (nxt_state == HOLD) || (nxt_state == APPLY);
         bus.done <= (nxt_state == DONE);
         if (go) begin
            len_q    <= len_in;
            hold_cnt <= HW'(RST_CYCLES - 1);
         end else if (state == HOLD && !hold_end) hold_cnt <= hold_cnt - HW'(1);
         // A zero-length start skips HOLD and leaves soc_rst where it was.
         if (go && nxt_state == HOLD) bus.soc_rst <= 1'b1;
         else if (hold_end) bus.soc_rst <= 1'b0;
         if (enter_step) begin
            bus.sw     <= SW_W'(rd_ent.sw);
            bus.button <= BTN_W'(rd_ent.btn);
            dwell_cnt  <= (ent_dwell == '0) ? '0 : ent_dwell - DWELL_W'(1);
         end else begin
            if (nxt_state != APPLY) begin
               bus.sw     <= '0;
               bus.button <= '0;
            end
            if (state == APPLY && dwell_cnt != '0) dwell_cnt <= dwell_cnt - DWELL_W'(1);
         end
      end
   end
   assign bus.step_idx = step_idx;
`ifdef SOC_STIM_LED_CHECK_EN
   logic [LED_W-1:0]     exp_q, mask_q;
   logic [ERR_CNT_W-1:0] err_q;
   logic                 hit;
   assign hit = step_end && |((bus.led ^ exp_q) & mask_q);
   always_ff @(posedge fpga_clk) begin
      if (fpga_rst) begin
         exp_q        <= '0;
         mask_q       <= '0;
         err_q        <= '0;
         bus.mismatch <= 1'b0;
      end else begin
         if (enter_step) begin
            exp_q  <= LED_W'(rd_ent.exp_led);
            mask_q <= LED_W'(rd_ent.led_mask);
         end
         bus.mismatch <= hit;
         if (go) err_q <= '0;
         else if (hit && err_q != '1) err_q <= err_q + ERR_CNT_W'(1);
      end
   end
   assign bus.err_count = err_q;
`else
   logic unused_led;
   assign unused_led    = ^bus.led;
   assign bus.mismatch  = 1'b0;
   assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_soc_stim_sequencer.sv
// tb_soc_stim_sequencer: directed bench for soc_stim_sequencer with hand-computed cycle expectations.
// SOC_STIM_LED_CHECK_EN additionally exercises the LED compare path.
module tb_soc_stim_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   soc_stim_sequencer_if bus ();
   soc_stim_sequencer #(.RST_CYCLES(1000)) dut (
      .fpga_clk (clk),
      .fpga_rst (rst),
      .bus      (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wr(input int a, input logic [23:0] s, input logic [4:0] b, input logic [31:0] d,
                     input logic [23:0] e, input logic [23:0] m);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 3'(a);
      bus.cfg_sw    = s;
      bus.cfg_btn   = b;
      bus.cfg_dwell = d;
`ifdef SOC_STIM_LED_CHECK_EN
      bus.cfg_exp_led  = e;
      bus.cfg_led_mask = m;
`else
      if (e !== m) bus.led = 24'h0;
`endif
      tick(1);
      bus.cfg_we = 1'b0;
   endtask
   task automatic run(input int len);
      bus.cfg_len = 4'(len);
      bus.start   = 1'b1;
      tick(1);
      bus.start   = 1'b0;
   endtask
   initial begin
      logic [23:0] pat [14];
      bus.start = 0; bus.loop_en = 0; bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_sw = 0;
      bus.cfg_btn = 0; bus.cfg_dwell = 0; bus.cfg_len = 0; bus.led = 0;
`ifdef SOC_STIM_LED_CHECK_EN
      bus.cfg_exp_led = 0; bus.cfg_led_mask = 0;
`endif
      tick(3);
      chk("rst_soc_rst", bus.soc_rst, 1);
      chk("rst_sw", bus.sw, 0);
      chk("rst_button", bus.button, 0);
      chk("rst_step", bus.step_idx, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_mismatch", bus.mismatch, 0);
      chk("rst_err", bus.err_count, 0);
      rst = 1'b0;
      // Long plan: five steps of 10000 cycles after a 1000-cycle hold.
      for (int i = 0; i < 5; i++) wr(i, (i == 4) ? 24'd0 : 24'(i), 5'(i), 10000, 0, 0);
      run(5);
      chk("t1_busy", bus.busy, 1);
      chk("t1_hold_rst", bus.soc_rst, 1);
      tick(999);
      chk("t1_hold_end_rst", bus.soc_rst, 1);
      chk("t1_hold_sw", bus.sw, 0);
      tick(1);
      chk("t1_release", bus.soc_rst, 0);
      chk("t1_step0_sw", bus.sw, 0);
      tick(9999);
      chk("t1_step0_last", bus.step_idx, 0);
      tick(1);
      chk("t1_step1_sw", bus.sw, 1);
      chk("t1_step1_btn", bus.button, 1);
      chk("t1_step1_idx", bus.step_idx, 1);
      tick(9999);
      chk("t1_step1_last", bus.sw, 1);
      tick(1);
      chk("t1_step2_sw", bus.sw, 2);
      tick(29999);
      chk("t1_last_idx", bus.step_idx, 4);
      chk("t1_last_busy", bus.busy, 1);
      chk("t1_last_done", bus.done, 0);
      tick(1);
      chk("t1_done", bus.done, 1);
      chk("t1_done_busy", bus.busy, 0);
      chk("t1_done_soc_rst", bus.soc_rst, 0);
      chk("t1_done_sw", bus.sw, 0);
      // Looping: 3 cycles of A then 4 of B, repeating.
      wr(0, 24'hAAAAAA, 5'd1, 3, 0, 0);
      wr(1, 24'hBBBBBB, 5'd2, 4, 0, 0);
      bus.loop_en = 1'b1;
      run(2);
      tick(1000);
      for (int i = 0; i < 14; i++) pat[i] = ((i % 7) < 3) ? 24'hAAAAAA : 24'hBBBBBB;
      for (int i = 0; i < 14; i++) begin
         chk($sformatf("t2_loop_sw%0d", i), bus.sw, pat[i]);
         if (i == 7) chk("t2_wrap_no_hold", bus.soc_rst, 0);
         tick(1);
      end
      bus.loop_en = 1'b0;
      chk("t2_pass3_a", bus.sw, 24'hAAAAAA);
      tick(6);
      chk("t2_pass3_b", bus.sw, 24'hBBBBBB);
      chk("t2_pass3_busy", bus.busy, 1);
      tick(1);
      chk("t2_stop_done", bus.done, 1);
      chk("t2_stop_sw", bus.sw, 0);
      // Dwell 0 behaves as a single cycle.
      wr(0, 24'h000111, 5'd3, 0, 0, 0);
      wr(1, 24'h000222, 5'd4, 2, 0, 0);
      run(2);
      tick(1000);
      chk("t3_d0_sw", bus.sw, 24'h111);
      tick(1);
      chk("t3_d0_next", bus.sw, 24'h222);
      tick(2);
      chk("t3_d0_done", bus.done, 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      run(0);
      chk("t3_len0_done", bus.done, 1);
      chk("t3_len0_busy", bus.busy, 0);
      chk("t3_len0_soc_rst", bus.soc_rst, 1);
      // Reset mid-APPLY, then replay.
      run(2);
      tick(1001);
      chk("t4_pre_sw", bus.sw, 24'h222);
      rst = 1'b1;
      tick(1);
      chk("t4_rst_soc_rst", bus.soc_rst, 1);
      chk("t4_rst_sw", bus.sw, 0);
      chk("t4_rst_step", bus.step_idx, 0);
      chk("t4_rst_busy", bus.busy, 0);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      chk("t4_rst_wins", bus.busy, 0);
      rst = 1'b0;
      run(2);
      tick(1000);
      chk("t4_replay0", bus.sw, 24'h111);
      tick(1);
      chk("t4_replay1", bus.sw, 24'h222);
      // Writes and starts during APPLY are ignored.
      bus.cfg_we = 1'b1; bus.cfg_addr = 0; bus.cfg_sw = 24'hFFF; bus.cfg_dwell = 0;
      bus.cfg_len = 1; bus.start = 1'b1;
      tick(1);
      bus.cfg_we = 1'b0; bus.start = 1'b0;
      chk("t5_busy_sw", bus.sw, 24'h222);
      chk("t5_busy", bus.busy, 1);
      tick(1);
      chk("t5_done", bus.done, 1);
      run(2);
      tick(1000);
      chk("t5_table_kept", bus.sw, 24'h111);
      tick(3);
      // Length above DEPTH is clamped to DEPTH.
      for (int i = 0; i < 8; i++) wr(i, 24'(8'h10 + i), 5'(i), 1, 0, 0);
      run(15);
      tick(1007);
      chk("t6_last_idx", bus.step_idx, 7);
      chk("t6_last_sw", bus.sw, 24'h17);
      tick(1);
      chk("t6_clamp_done", bus.done, 1);
      chk("t6_no_err", bus.err_count, 0);
`ifdef SOC_STIM_LED_CHECK_EN
      wr(0, 24'h1, 5'd0, 2, 24'h000001, 24'hFFFFFF);
      wr(1, 24'h2, 5'd0, 2, 24'h000001, 24'h000000);
      bus.led = 24'h0;
      run(2);
      tick(1001);
      chk("t7_no_early", bus.mismatch, 0);
      tick(1);
      chk("t7_mismatch", bus.mismatch, 1);
      chk("t7_err1", bus.err_count, 1);
      tick(1);
      chk("t7_pulse_end", bus.mismatch, 0);
      tick(1);
      chk("t7_mask0_ok", bus.mismatch, 0);
      chk("t7_err_kept", bus.err_count, 1);
      chk("t7_done", bus.done, 1);
      run(2);
      chk("t7_err_clr", bus.err_count, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
